state_dump_reader: RTL and testbench
====================================

Name: state_dump_reader

Overview:
- Hardware reader for architectural state in the MIPS-lite pipeline. After a start pulse it freezes the core and reads every register-file entry, then every data-memory word.
- Words leave on a valid/ready stream, each tagged with its address space and index.
- Sits beside mips_pipeline on the secondary read ports of the RF and DM. It is the synthesizable counterpart to bench-side preload/dump: it reads state out instead of writing it in.

Parameters:
- RF_DEPTH, 32, number of register-file entries read (indices 0..RF_DEPTH-1).
- DM_DEPTH, 32, number of data-memory words read; equals DATA_MEM_LENGTH.
- DM_AW, 5, data-memory word-address width.
- IDX_W, 5, out_index width; must be >= max(clog2(RF_DEPTH), DM_AW).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a dump; ignored while busy=1.
- busy  out  1  high from the cycle after an accepted start through the final handshake.
- done  out  1  one-cycle pulse the cycle after the final word handshakes.
- cpu_hold  out  1  freezes PC and pipeline registers; equal to busy.
- rf_raddr  out  5  RF debug read address.
- rf_rdata  in  32  RF debug read data, combinational (same-cycle) read.
- dm_raddr  out  DM_AW  DM debug read address.
- dm_rdata  in  32  DM debug read data, combinational read.
- out_valid  out  1  stream word valid.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- out_data  out  32  stream word.
- out_space  out  2  tag: 00=RF, 01=DM, 10=checksum, 11 unused.
- out_index  out  IDX_W  index of the word within its space.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, idx=0, busy=0, done=0, cpu_hold=0, out_valid=0, out_data=0, out_space=0, out_index=0, rf_raddr=0, dm_raddr=0.
- States: IDLE, RD_RF, RD_DM, CSUM (optional feature only), DRAIN.
- IDLE: start=1 at a clock edge → RD_RF, idx=0, busy=1 on the next cycle.
- Output stage is a one-entry register. "Slot free" means !out_valid || out_ready.
- RD_RF: rf_raddr=idx. When slot free, load out_data=rf_rdata, out_space=00, out_index=idx, out_valid=1, then idx+1.
  - When idx=RF_DEPTH-1 is loaded: idx=0, go to RD_DM.
- RD_DM: dm_raddr=idx, with the same load rule and out_space=01.
  - When idx=DM_DEPTH-1 is loaded: go to CSUM if enabled, else DRAIN.
- Read addresses change only when a word is loaded, so they stay stable during backpressure.
- While out_valid && !out_ready: out_data, out_space and out_index hold unchanged.
- DRAIN: wait for handshake of the last word. Then out_valid=0, busy=0, done=1 for one cycle, return to IDLE.
- If a handshake occurs with no new load, out_valid drops to 0.
- Throughput: with out_ready held at 1, one word per cycle.
  - First out_valid appears 2 cycles after the start edge.
  - Total dump takes RF_DEPTH+DM_DEPTH beats with no bubbles.
- start while busy: ignored, with no effect on idx or state. start coinciding with the done cycle is accepted, since the block is in IDLE.
- Reset mid-dump: everything returns to reset values immediately. cpu_hold drops and no done pulse is produced.
- idx is a counter of width IDX_W. It never exceeds DEPTH-1 and never wraps within a space.

Optional Feature:
- Macro: DUMP_CHECKSUM_EN.
- Defined:
  - A 32-bit accumulator clears on start and adds every loaded RF/DM word, modulo 2^32.
  - After the last DM word, state CSUM loads one extra word when the slot is free: out_data=sum, out_space=10, out_index=0. Then go to DRAIN.
  - Total beats = RF_DEPTH+DM_DEPTH+1.
- Undefined: no accumulator and no CSUM state. Tag 10 is never produced.

Test Plan:
- Reset: rst_n=0 mid-cycle → all outputs 0 asynchronously. With rst_n=1 and start=0, outputs stay idle.
- Full dump, out_ready=1, RF[i]=i, DM[i]=0x100+i:
  - Expect 64 consecutive beats: RF 0..31 (tag 00), then DM 0x100..0x11F (tag 01).
  - cpu_hold high throughout; done pulses one cycle after beat 64.
- Backpressure, out_ready toggled pseudo-randomly: the same 64 words arrive in order with no loss or duplication. Outputs stay stable whenever valid && !ready.
- Start while busy: pulse start at beat 10 → exactly one dump and one done pulse.
- Reset mid-dump at beat 20: busy, cpu_hold and out_valid drop immediately. A new start then restarts from RF index 0.
- With DUMP_CHECKSUM_EN and the same data: 65th beat has tag 10 and out_data=0x000023E0.

Source files
------------

// File: rtl/state_dump_reader.sv
// Freezes the core and streams every RF entry then every DM word; DUMP_CHECKSUM_EN appends a 32-bit sum word.
// Latency: first word valid on the second edge after start; one word per cycle when the consumer is ready.
// Backpressure: one-entry output register; words, tags and read addresses hold while out_valid && !out_ready.
module state_dump_reader #(
    parameter int RF_DEPTH = 32,
    parameter int DM_DEPTH = 32,
    parameter int DM_AW    = 5,
    parameter int IDX_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             cpu_hold,
    output logic [4:0]       rf_raddr,
    input  logic [31:0]      rf_rdata,
    output logic [DM_AW-1:0] dm_raddr,
    input  logic [31:0]      dm_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [1:0]       out_space,
    output logic [IDX_W-1:0] out_index
);

`ifdef DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, RD_RF, RD_DM, CSUM, DRAIN} state_t;
`else
    typedef enum logic [2:0] {IDLE, RD_RF, RD_DM, DRAIN} state_t;
`endif

    localparam logic [IDX_W-1:0] RF_LAST = IDX_W'(RF_DEPTH - 1);
    localparam logic [IDX_W-1:0] DM_LAST = IDX_W'(DM_DEPTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_inc;
    logic             slot_free;

`ifdef DUMP_CHECKSUM_EN
    logic [31:0]      sum;
`endif

    assign slot_free = !out_valid || out_ready;
    assign idx_inc   = idx + IDX_ONE;
    assign cpu_hold  = busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_space <= '0;
            out_index <= '0;
            rf_raddr  <= '0;
            dm_raddr  <= '0;
`ifdef DUMP_CHECKSUM_EN
            sum       <= '0;
`endif
        end else begin
            done <= 1'b0;
            // A consumed word with no replacement empties the slot; loads below override this.
            if (out_valid && out_ready)
                out_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RD_RF;
                        idx      <= '0;
                        busy     <= 1'b1;
                        rf_raddr <= '0;
                        dm_raddr <= '0;
`ifdef DUMP_CHECKSUM_EN
                        sum      <= '0;
`endif
                    end
                end
                RD_RF: begin
                    if (slot_free) begin
                        out_valid <= 1'b1;
                        out_data  <= rf_rdata;
                        out_space <= 2'b00;
                        out_index <= idx;
`ifdef DUMP_CHECKSUM_EN
                        sum       <= sum + rf_rdata;
`endif
                        if (idx == RF_LAST) begin
                            idx   <= '0;
                            state <= RD_DM;
                        end else begin
                            idx      <= idx_inc;
                            rf_raddr <= 5'(idx_inc);
                        end
                    end
                end
                RD_DM: begin
                    if (slot_free) begin
                        out_valid <= 1'b1;
                        out_data  <= dm_rdata;
                        out_space <= 2'b01;
                        out_index <= idx;
`ifdef DUMP_CHECKSUM_EN
                        sum       <= sum + dm_rdata;
`endif
                        if (idx == DM_LAST) begin
                            idx   <= '0;
`ifdef DUMP_CHECKSUM_EN
                            state <= CSUM;
`else
                            state <= DRAIN;
`endif
                        end else begin
                            idx      <= idx_inc;
                            dm_raddr <= DM_AW'(idx_inc);
                        end
                    end
                end
`ifdef DUMP_CHECKSUM_EN
                CSUM: begin
                    if (slot_free) begin
                        out_valid <= 1'b1;
                        out_data  <= sum;
                        out_space <= 2'b10;
                        out_index <= '0;
                        state     <= DRAIN;
                    end
                end
`endif
                DRAIN: begin
                    // Slot always holds the final word here; its handshake ends the dump.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_state_dump_reader.sv
// Randomized bench for state_dump_reader: expected word stream is built from the memory arrays.
module tb_state_dump_reader;

    localparam int RF_DEPTH = 32;
    localparam int DM_DEPTH = 32;
    localparam int DM_AW    = 5;
    localparam int IDX_W    = 5;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             busy;
    logic             done;
    logic             cpu_hold;
    logic [4:0]       rf_raddr;
    logic [31:0]      rf_rdata;
    logic [DM_AW-1:0] dm_raddr;
    logic [31:0]      dm_rdata;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [1:0]       out_space;
    logic [IDX_W-1:0] out_index;

    logic [31:0] rf_mem [RF_DEPTH];
    logic [31:0] dm_mem [DM_DEPTH];
    logic [63:0] expq [$];

    int total = 0;
    int bad   = 0;

    state_dump_reader #(
        .RF_DEPTH(RF_DEPTH), .DM_DEPTH(DM_DEPTH), .DM_AW(DM_AW), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .cpu_hold(cpu_hold), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .dm_raddr(dm_raddr), .dm_rdata(dm_rdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_space(out_space),
        .out_index(out_index)
    );

    assign rf_rdata = rf_mem[rf_raddr];
    assign dm_rdata = dm_mem[dm_raddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] cur_word();
        return 64'({out_space, out_index, out_data});
    endfunction

    function automatic logic [63:0] mk_word(input logic [1:0] sp, input int i, input logic [31:0] d);
        return 64'({sp, IDX_W'(i), d});
    endfunction

    // Reference stream: all RF entries, all DM words, then the modular sum when enabled.
    task automatic build_expected();
        logic [31:0] s;
        s = 32'h0;
        expq.delete();
        for (int i = 0; i < RF_DEPTH; i++) begin
            expq.push_back(mk_word(2'b00, i, rf_mem[i]));
            s = s + rf_mem[i];
        end
        for (int i = 0; i < DM_DEPTH; i++) begin
            expq.push_back(mk_word(2'b01, i, dm_mem[i]));
            s = s + dm_mem[i];
        end
`ifdef DUMP_CHECKSUM_EN
        expq.push_back(mk_word(2'b10, 0, s));
`endif
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ctl"}, 64'({busy, done, cpu_hold, out_valid}), 64'h0);
        chk({tag, "_dat"}, cur_word(), 64'h0);
        chk({tag, "_addr"}, 64'({rf_raddr, dm_raddr}), 64'h0);
    endtask

    // pct: out_ready probability; start_beat: re-pulse start mid-dump; abort_beat: reset mid-dump.
    task automatic run_dump(input int pct, input int start_beat, input int abort_beat);
        int          n;
        int          beats;
        bit          stalled;
        bit          hs_last;
        bit          finished;
        logic [63:0] word;
        logic [63:0] prev_word;

        build_expected();
        n        = expq.size();
        beats    = 0;
        stalled  = 1'b0;
        hs_last  = 1'b0;
        finished = 1'b0;
        prev_word = '0;

        @(posedge clk); #1;
        start     = 1'b1;
        out_ready = ($urandom_range(99) < pct);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_on", 64'(busy), 64'h1);

        for (int cyc = 1; cyc <= 3000 && !finished; cyc++) begin
            @(negedge clk);
            word = cur_word();
            if (stalled)
                chk("hold_stable", word, prev_word);
            if (hs_last) begin
                chk("done_pulse", 64'(done), 64'h1);
                chk("busy_off", 64'({busy, cpu_hold, out_valid}), 64'h0);
                if (pct == 100)
                    chk("dump_cycles", 64'(cyc), 64'(n + 2));
                finished = 1'b1;
            end else begin
                chk("busy_hold", 64'({busy, cpu_hold, done}), 64'h6);
                if (out_valid && out_ready) begin
                    if (beats < n)
                        chk("beat", word, expq[beats]);
                    else
                        chk("extra_beat", 64'(beats), 64'(n));
                    beats++;
                    if (beats == n)
                        hs_last = 1'b1;
                end
                if (abort_beat > 0 && beats == abort_beat) begin
                    #1 rst_n = 1'b0;
                    #1 check_idle_outputs("abort_rst");
                    start = 1'b0;
                    @(posedge clk); #1;
                    rst_n = 1'b1;
                    return;
                end
            end
            stalled   = out_valid && !out_ready;
            prev_word = word;
            if (!finished) begin
                @(posedge clk); #1;
                out_ready = ($urandom_range(99) < pct);
                start     = (start_beat > 0 && beats == start_beat);
            end
        end
        start = 1'b0;
        if (!finished)
            chk("timeout", 64'(beats), 64'(n));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_idle", 64'({busy, done, out_valid}), 64'h0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < RF_DEPTH; i++) rf_mem[i] = 32'(i);
        for (int i = 0; i < DM_DEPTH; i++) dm_mem[i] = 32'h100 + 32'(i);

        repeat (3) @(posedge clk);
        #1 check_idle_outputs("reset");
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_idle_outputs("idle");
        end

        run_dump(100, 0, 0);
        run_dump(100, 10, 0);
        run_dump(50, 0, 0);

        for (int i = 0; i < RF_DEPTH; i++) rf_mem[i] = $urandom;
        for (int i = 0; i < DM_DEPTH; i++) dm_mem[i] = $urandom;
        run_dump(30, 0, 0);
        run_dump(70, 7, 0);
        run_dump(100, 0, 20);
        run_dump(60, 0, 20);
        run_dump(100, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
